// File: rtl/sprite_layer_mixer_if.sv
// Pixel-side bundle for the sprite layer mixer:
// layer inputs from the CLUT stage, composited results out.
interface sprite_layer_mixer_if #(
  parameter int LAYERS = 6,
  parameter int COLRW  = 12
);
  logic                    frame;
  logic                    de;
  logic [LAYERS-1:0]       layer_draw;
  logic [LAYERS*COLRW-1:0] layer_colr;
  logic [COLRW-1:0]        bg_colr;
  logic                    restart;
  logic [COLRW-1:0]        paint_colr;
  logic [LAYERS-1:0]       hit_mask;
  logic                    hit;
  logic [3:0]              lives;
  logic [1:0]              state;

  modport master (
    output frame, de, layer_draw, layer_colr,
    output bg_colr, restart,
    input  paint_colr, hit_mask, hit, lives, state
  );

  modport slave (
    input  frame, de, layer_draw, layer_colr,
    input  bg_colr, restart,
    output paint_colr, hit_mask, hit, lives, state
  );
endinterface

// File: rtl/sprite_layer_mixer.sv
// N-layer priority compositor with player collision and lives FSM.
// Option: SPRITE_LAYER_MIXER_BLINK_EN blinks the player while invulnerable.
module sprite_layer_mixer #(
  parameter int LAYERS        = 6,
  parameter int COLRW         = 12,
  parameter int PLAYER_LAYER  = 0,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic                 clk_pix,
  input  logic                 rst_pix_n,
  sprite_layer_mixer_if.slave  bus
);

  localparam int CW = $clog2(INVULN_FRAMES + 1);
  localparam logic [CW-1:0] INV_LD = CW'(INVULN_FRAMES);
  localparam logic [3:0] LIVES_LD = 4'(LIVES);

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } st_t;

  st_t               st_q;
  logic [CW-1:0]     cnt_q;
  logic [LAYERS-1:0] accum_q;
  logic [LAYERS-1:0] draw_c;
  logic [LAYERS-1:0] ovl;
  logic              any_ovl;
  logic              blank;
  logic [COLRW-1:0]  pick;

`ifdef SPRITE_LAYER_MIXER_BLINK_EN
  logic [7:0] cnt_ext;
  assign cnt_ext = 8'(cnt_q);
  assign blank = (st_q == INVULN) & cnt_ext[2];
`else
  assign blank = 1'b0;
`endif

  // Draw flags used for compositing (player may be blanked)
  always_comb begin
    draw_c = bus.layer_draw;
    draw_c[PLAYER_LAYER] = bus.layer_draw[PLAYER_LAYER] & ~blank;
  end

  // Priority mux: lowest drawing index wins, else background
  always_comb begin
    pick = bus.bg_colr;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (draw_c[i]) pick = bus.layer_colr[i*COLRW +: COLRW];
    end
  end

  // Layers overlapping the player this pixel (raw draw flags)
  always_comb begin
    ovl = '0;
    if (bus.de & bus.layer_draw[PLAYER_LAYER]) ovl = bus.layer_draw;
    ovl[PLAYER_LAYER] = 1'b0;
  end

  assign any_ovl = |ovl;

  // Registered composited colour
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) bus.paint_colr <= '0;
    else bus.paint_colr <= bus.de ? pick : '0;
  end

  // Per-frame overlap accumulation and snapshot
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      accum_q      <= '0;
      bus.hit_mask <= '0;
    end else if (bus.frame) begin
      accum_q      <= '0;
      bus.hit_mask <= accum_q | ovl;
    end else begin
      accum_q <= accum_q | ovl;
    end
  end

  // Player life / invulnerability FSM
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      st_q      <= ALIVE;
      cnt_q     <= '0;
      bus.lives <= LIVES_LD;
      bus.hit   <= 1'b0;
    end else begin
      bus.hit <= 1'b0;
      unique case (st_q)
        ALIVE: begin
          if (any_ovl) begin
            bus.hit <= 1'b1;
            if (bus.lives <= 4'd1) begin
              bus.lives <= 4'd0;
              st_q      <= DEAD;
            end else begin
              bus.lives <= bus.lives - 4'd1;
              st_q      <= INVULN;
              cnt_q     <= INV_LD;
            end
          end
        end
        INVULN: begin
          if (bus.frame) begin
            if (cnt_q <= CW'(1)) begin
              cnt_q <= '0;
              st_q  <= ALIVE;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        DEAD: begin
          if (bus.restart) begin
            st_q      <= ALIVE;
            bus.lives <= LIVES_LD;
          end
        end
        default: st_q <= ALIVE;
      endcase
    end
  end

  assign bus.state = st_q;

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Scoreboard bench for sprite_layer_mixer: a spec-level model
// queues expected outputs per driven cycle, popped after the edge.
module tb_sprite_layer_mixer;

  localparam int L  = 6;
  localparam int C  = 12;
  localparam int P  = 0;
  localparam int LV = 3;
  localparam int IF = 4;

  typedef struct packed {
    logic [C-1:0] paint;
    logic [L-1:0] hm;
    logic         hit;
    logic [3:0]   lives;
    logic [1:0]   st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sprite_layer_mixer_if #(.LAYERS(L), .COLRW(C)) bus ();

  sprite_layer_mixer #(
    .LAYERS(L), .COLRW(C), .PLAYER_LAYER(P),
    .LIVES(LV), .INVULN_FRAMES(IF)
  ) dut (
    .clk_pix(clk),
    .rst_pix_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic [C-1:0] colr [L];
  logic [C-1:0] bg = 12'h0B0;

  int m_lives, m_st, m_cnt;
  logic [L-1:0] m_acc, m_hm;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_lives = LV;
    m_st    = 0;
    m_cnt   = 0;
    m_acc   = '0;
    m_hm    = '0;
  endtask

  task automatic drive(input logic fr, input logic d,
                       input logic [L-1:0] dr, input logic rs);
    exp_t e;
    logic [L-1:0] vis, ovl;
    bus.frame      = fr;
    bus.de         = d;
    bus.layer_draw = dr;
    bus.restart    = rs;
    bus.bg_colr    = bg;
    for (int i = 0; i < L; i++) bus.layer_colr[i*C +: C] = colr[i];
    vis = dr;
`ifdef SPRITE_LAYER_MIXER_BLINK_EN
    if (m_st == 1 && ((m_cnt >> 2) & 1) == 1) vis[P] = 1'b0;
`endif
    e.paint = '0;
    if (d) begin
      e.paint = bg;
      for (int i = 0; i < L; i++) begin
        if (vis[i]) begin
          e.paint = colr[i];
          break;
        end
      end
    end
    ovl = (d && dr[P]) ? dr : '0;
    ovl[P] = 1'b0;
    if (fr) begin
      m_hm  = m_acc | ovl;
      m_acc = '0;
    end else begin
      m_acc = m_acc | ovl;
    end
    e.hit = 1'b0;
    case (m_st)
      0: if (ovl != 0) begin
        e.hit = 1'b1;
        m_lives = m_lives - 1;
        m_st = (m_lives == 0) ? 2 : 1;
        m_cnt = IF;
      end
      1: if (fr) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_st = 0;
      end
      default: if (rs) begin
        m_st = 0;
        m_lives = LV;
      end
    endcase
    e.hm    = m_hm;
    e.lives = 4'(m_lives);
    e.st    = 2'(m_st);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("q_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("paint", 32'(bus.paint_colr), 32'(e.paint));
      chk("hit_mask", 32'(bus.hit_mask), 32'(e.hm));
      chk("hit", 32'(bus.hit), 32'(e.hit));
      chk("lives", 32'(bus.lives), 32'(e.lives));
      chk("state", 32'(bus.state), 32'(e.st));
    end
  endtask

  task automatic reset_and_check(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    chk({tag, "_paint"}, 32'(bus.paint_colr), 32'd0);
    chk({tag, "_hm"}, 32'(bus.hit_mask), 32'd0);
    chk({tag, "_hit"}, 32'(bus.hit), 32'd0);
    chk({tag, "_lives"}, 32'(bus.lives), 32'(LV));
    chk({tag, "_state"}, 32'(bus.state), 32'd0);
    model_reset();
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    colr[0] = 12'hA0F;
    colr[1] = 12'h111;
    colr[2] = 12'h123;
    colr[3] = 12'h333;
    colr[4] = 12'h456;
    colr[5] = 12'h555;
    bus.frame      = 1'b0;
    bus.de         = 1'b0;
    bus.layer_draw = '0;
    bus.layer_colr = '0;
    bus.bg_colr    = bg;
    bus.restart    = 1'b0;
    model_reset();
    @(negedge clk);
    reset_and_check("rst0");

    // compositing priority, de gating, background
    drive(1'b0, 1'b1, 6'b010100, 1'b0);
    drive(1'b0, 1'b0, 6'b010100, 1'b0);
    drive(1'b0, 1'b1, 6'b000000, 1'b0);
    drive(1'b0, 1'b1, 6'b100000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'($urandom_range(1)),
            6'($urandom) & 6'b111110, 1'b0);
    end
    drive(1'b0, 1'b1, 6'b000010, 1'b1);

    // single overlap hit, blink window, hit_mask on frame
    drive(1'b0, 1'b1, 6'b001001, 1'b0);
    drive(1'b0, 1'b1, 6'b000001, 1'b0);
    drive(1'b0, 1'b1, 6'b000000, 1'b0);
    drive(1'b1, 1'b1, 6'b000000, 1'b0);
    drive(1'b0, 1'b1, 6'b000001, 1'b0);

    // continuous overlap through invulnerability until dead
    for (int k = 0; k < 40; k++) begin
      drive(1'((k % 3) == 2), 1'b1, 6'b000011, 1'b0);
    end
    drive(1'b0, 1'b1, 6'b000011, 1'b1);
    drive(1'b1, 1'b1, 6'b000000, 1'b0);

    // overlap coincident with frame; overlap at final frame ignored
    drive(1'b1, 1'b1, 6'b010001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 6'b000000, 1'b0);
      drive(1'b1, 1'b1, 6'b000101, 1'b0);
    end
    drive(1'b0, 1'b1, 6'b000000, 1'b0);
    drive(1'b1, 1'b1, 6'b000000, 1'b0);

    // reset in the middle of invulnerability
    drive(1'b0, 1'b1, 6'b000011, 1'b0);
    drive(1'b1, 1'b1, 6'b000000, 1'b0);
    drive(1'b0, 1'b1, 6'b000100, 1'b0);
    reset_and_check("rst_mid");
    drive(1'b0, 1'b1, 6'b000100, 1'b0);
    drive(1'b0, 1'b1, 6'b001001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
